// File: rtl/addr_decoder_pkg.sv
// Shared constants for the I/O address decoder: op encodings, config map offsets,
// reset values of a window, stretch timeout length, and the decode result type.
package addr_decoder_pkg;

    localparam logic [7:0] OP_WRITE = 8'h00;
    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_ANY   = 8'hFF;

    localparam logic [7:0] CFG_BASE_OFS = 8'h00;
    localparam logic [7:0] CFG_MASK_OFS = 8'h04;
    localparam logic [7:0] CFG_SLOT_OFS = 8'h08;
    localparam logic [7:0] CFG_OP_OFS   = 8'h0C;

    localparam logic [7:0] RST_BASE = 8'h00;
    localparam logic [7:0] RST_MASK = 8'h00;
    localparam logic [7:0] RST_SLOT = 8'h00;
    localparam logic [7:0] RST_OP   = OP_ANY;

    localparam int READY_TIMEOUT = 256;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } cyc_state_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] idx;
        logic [2:0] slot;
    } dec_t;

    // bit1 set means either direction; otherwise bit0 picks read-only or write-only
    function automatic logic op_allows(input logic [7:0] op, input logic rd);
        if (op[1])
            return 1'b1;
        else if (op[0] == OP_READ[0])
            return rd;
        else
            return (op[0] == OP_WRITE[0]) && !rd;
    endfunction

endpackage

// File: rtl/addr_decoder_cfg_regs.sv
// Window register file (base/mask/slot/op per window), written on clk.
// Write takes effect on the next edge; addresses 0x10 and above are dropped.
module addr_decoder_cfg_regs
    import addr_decoder_pkg::*;
#(
    parameter int NUM_WIN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_addr,
    input  logic [7:0]           cfg_wdata,
    output logic [NUM_WIN*8-1:0] base_flat,
    output logic [NUM_WIN*8-1:0] mask_flat,
    output logic [NUM_WIN*8-1:0] slot_flat,
    output logic [NUM_WIN*8-1:0] op_flat
);

    logic [7:0] base_q [NUM_WIN];
    logic [7:0] mask_q [NUM_WIN];
    logic [7:0] slot_q [NUM_WIN];
    logic [7:0] op_q   [NUM_WIN];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                base_q[i] <= RST_BASE;
                mask_q[i] <= RST_MASK;
                slot_q[i] <= RST_SLOT;
                op_q[i]   <= RST_OP;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                if (int'(cfg_addr[1:0]) == i) begin
                    // upper six address bits pick the register bank; anything else is ignored
                    case (cfg_addr[7:2])
                        CFG_BASE_OFS[7:2]: base_q[i] <= cfg_wdata;
                        CFG_MASK_OFS[7:2]: mask_q[i] <= cfg_wdata;
                        CFG_SLOT_OFS[7:2]: slot_q[i] <= cfg_wdata;
                        CFG_OP_OFS[7:2]:   op_q[i]   <= cfg_wdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_WIN; g++) begin : g_flat
        assign base_flat[g*8 +: 8] = base_q[g];
        assign mask_flat[g*8 +: 8] = mask_q[g];
        assign slot_flat[g*8 +: 8] = slot_q[g];
        assign op_flat[g*8 +: 8]   = op_q[g];
    end

endmodule

// File: rtl/addr_decoder.sv
// I/O address decoder: window match, lowest-index priority, per-cycle latch of chip select.
// Latency: 1 clk from iorq_n sampled low to registered decode; ready_n stretches on busy slot.
// Optional ADDR_DECODER_READY_TIMEOUT_EN caps a stretch at 256 cycles.
module addr_decoder
    import addr_decoder_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int NUM_WIN   = 4,
    parameter int NUM_SLOTS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 iorq_n,
    input  logic                 r_w_,
    input  logic [NUM_SLOTS-1:0] dev_ready_n,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_addr,
    input  logic [7:0]           cfg_wdata,
    output logic                 ready_n,
    output logic                 io_r_w_,
    output logic                 data_oe_n,
    output logic                 data_dir,
    output logic                 ff_oe_n,
    output logic                 win_valid,
    output logic [3:0]           win_index,
    output logic [2:0]           sel_slot,
    output logic [NUM_SLOTS-1:0] cs_n
);

    logic [NUM_WIN*8-1:0] base_flat;
    logic [NUM_WIN*8-1:0] mask_flat;
    logic [NUM_WIN*8-1:0] slot_flat;
    logic [NUM_WIN*8-1:0] op_flat;

    addr_decoder_cfg_regs #(.NUM_WIN(NUM_WIN)) u_cfg_regs (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .base_flat (base_flat),
        .mask_flat (mask_flat),
        .slot_flat (slot_flat),
        .op_flat   (op_flat)
    );

    dec_t       dec;
    cyc_state_t state_q, state_d;
    logic       start;
    logic       cur_vld;
    logic [2:0] cur_slot;
    logic       busy;
    logic       stretch;

    // walk from the top so the lowest matching window is the last one assigned
    always_comb begin
        dec = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if ((((addr ^ base_flat[i*8 +: 8]) & mask_flat[i*8 +: 8]) == '0) &&
                op_allows(op_flat[i*8 +: 8], r_w_) &&
                (slot_flat[i*8 +: 8] < 8'(NUM_SLOTS))) begin
                dec.vld  = 1'b1;
                dec.idx  = 4'(i);
                dec.slot = slot_flat[i*8 +: 3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!iorq_n) begin
                    state_d = ST_ACTIVE;
                    start   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (iorq_n)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // on the start edge the fresh decode governs ready_n; afterwards the latched one does
    always_comb begin
        cur_vld  = start ? dec.vld  : win_valid;
        cur_slot = start ? dec.slot : sel_slot;
        busy     = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (cur_slot == 3'(s))
                busy = ~dev_ready_n[s];
        end
        stretch = (state_d == ST_ACTIVE) && cur_vld && busy;
    end

    always_ff @(posedge clk) begin
        if (rst || (state_d == ST_IDLE)) begin
            win_valid <= 1'b0;
            win_index <= '0;
            sel_slot  <= '0;
            io_r_w_   <= 1'b1;
            cs_n      <= '1;
            data_oe_n <= 1'b1;
            data_dir  <= 1'b0;
            ff_oe_n   <= 1'b1;
        end else if (start) begin
            win_valid <= dec.vld;
            win_index <= dec.idx;
            sel_slot  <= dec.slot;
            io_r_w_   <= r_w_;
            cs_n      <= dec.vld ? ~(NUM_SLOTS'(1) << dec.slot) : '1;
            data_oe_n <= ~dec.vld;
            data_dir  <= dec.vld & r_w_;
            ff_oe_n   <= dec.vld | ~r_w_;
        end
    end

`ifdef ADDR_DECODER_READY_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(READY_TIMEOUT - 1);

    logic [7:0] stall_cnt;
    logic       timed_out;
    logic       tmo_hit;

    assign tmo_hit = !ready_n && (stall_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst || (state_d == ST_IDLE)) begin
            stall_cnt <= '0;
            timed_out <= 1'b0;
            ready_n   <= 1'b1;
        end else begin
            stall_cnt <= ready_n ? 8'd0 : stall_cnt + 8'd1;
            if (tmo_hit)
                timed_out <= 1'b1;
            ready_n <= !(stretch && !timed_out && !tmo_hit);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst)
            ready_n <= 1'b1;
        else
            ready_n <= !stretch;
    end
`endif

endmodule

// File: tb/tb_addr_decoder.sv
// Directed bench for addr_decoder: cycle model of the decoder rules checked every cycle,
// plus literal expectations on the key vectors.
module tb_addr_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] addr;
    logic       iorq_n;
    logic       r_w_;
    logic [4:0] dev_ready_n;
    logic       cfg_we;
    logic [7:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       ready_n;
    logic       io_r_w_;
    logic       data_oe_n;
    logic       data_dir;
    logic       ff_oe_n;
    logic       win_valid;
    logic [3:0] win_index;
    logic [2:0] sel_slot;
    logic [4:0] cs_n;

    int total = 0;
    int bad   = 0;

    addr_decoder #(.ADDR_W(8), .NUM_WIN(4), .NUM_SLOTS(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .iorq_n      (iorq_n),
        .r_w_        (r_w_),
        .dev_ready_n (dev_ready_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .ready_n     (ready_n),
        .io_r_w_     (io_r_w_),
        .data_oe_n   (data_oe_n),
        .data_dir    (data_dir),
        .ff_oe_n     (ff_oe_n),
        .win_valid   (win_valid),
        .win_index   (win_index),
        .sel_slot    (sel_slot),
        .cs_n        (cs_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_base [4];
    int  m_mask [4];
    int  m_slot [4];
    int  m_op   [4];
    bit  m_active;
    bit  m_hit;
    int  m_idx;
    int  m_sel;
    bit  m_rd;
    bit  m_ready;
    int  m_lowrun;
    bit  m_tmo;
    bit  chk_en = 1'b0;

    function automatic void mdecode(input int a, input bit rd, output bit hit, output int idx, output int sl);
        bit dir_ok;
        hit = 1'b0;
        idx = 0;
        sl  = 0;
        for (int i = 0; i < 4; i++) begin
            if ((m_op[i] & 2) != 0)
                dir_ok = 1'b1;
            else if ((m_op[i] & 1) != 0)
                dir_ok = rd;
            else
                dir_ok = !rd;
            if (!hit && (((a ^ m_base[i]) & m_mask[i]) == 0) && dir_ok && (m_slot[i] < 5)) begin
                hit = 1'b1;
                idx = i;
                sl  = m_slot[i];
            end
        end
    endfunction

    always @(posedge clk) begin
        bit stretch;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_base[i] = 0;
                m_mask[i] = 0;
                m_slot[i] = 0;
                m_op[i]   = 255;
            end
            m_active = 1'b0;
            m_hit    = 1'b0;
            m_idx    = 0;
            m_sel    = 0;
            m_rd     = 1'b1;
            m_ready  = 1'b1;
            m_lowrun = 0;
            m_tmo    = 1'b0;
            chk_en   = 1'b1;
        end else begin
            if (!m_active && !iorq_n) begin
                m_active = 1'b1;
                m_rd     = r_w_;
                mdecode(int'(addr), r_w_, m_hit, m_idx, m_sel);
            end else if (m_active && iorq_n) begin
                m_active = 1'b0;
                m_tmo    = 1'b0;
            end
            stretch = m_active && m_hit && (dev_ready_n[m_sel] == 1'b0);
`ifdef ADDR_DECODER_READY_TIMEOUT_EN
            if (stretch && !m_tmo) begin
                if (m_lowrun == 256) begin
                    m_tmo    = 1'b1;
                    m_ready  = 1'b1;
                    m_lowrun = 0;
                end else begin
                    m_ready  = 1'b0;
                    m_lowrun++;
                end
            end else begin
                m_ready  = 1'b1;
                m_lowrun = 0;
            end
`else
            m_ready = !stretch;
`endif
            // config writes land after the decode of the same edge
            if (cfg_we && cfg_addr < 8'h10) begin
                case (int'(cfg_addr) / 4)
                    0: m_base[int'(cfg_addr) % 4] = int'(cfg_wdata);
                    1: m_mask[int'(cfg_addr) % 4] = int'(cfg_wdata);
                    2: m_slot[int'(cfg_addr) % 4] = int'(cfg_wdata);
                    default: m_op[int'(cfg_addr) % 4] = int'(cfg_wdata);
                endcase
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] e_cs;
        bit mapped;
        if (chk_en) begin
            mapped = m_active && m_hit;
            e_cs = 5'b11111;
            if (mapped)
                e_cs[m_sel] = 1'b0;
            chk("m_cs_n", 32'(cs_n), 32'(e_cs));
            chk("m_ready_n", 32'(ready_n), 32'(m_ready));
            chk("m_win_valid", 32'(win_valid), 32'(mapped));
            chk("m_win_index", 32'(win_index), mapped ? m_idx : 0);
            chk("m_sel_slot", 32'(sel_slot), mapped ? m_sel : 0);
            chk("m_io_r_w", 32'(io_r_w_), m_active ? 32'(m_rd) : 32'd1);
            chk("m_data_oe_n", 32'(data_oe_n), 32'(!mapped));
            chk("m_data_dir", 32'(data_dir), 32'(mapped && m_rd));
            chk("m_ff_oe_n", 32'(ff_oe_n), 32'(!(m_active && !m_hit && m_rd)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cfg_wr(input logic [7:0] a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic start_cyc(input logic [7:0] a, input logic rd);
        addr   = a;
        r_w_   = rd;
        iorq_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic end_cyc();
        iorq_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 1'b1; addr = 8'h00; iorq_n = 1'b1; r_w_ = 1'b1;
        dev_ready_n = 5'b11111; cfg_we = 1'b0; cfg_addr = 8'h00; cfg_wdata = 8'h00;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cs_n", 32'(cs_n), 32'h1F);
        chk("rst_ready_n", 32'(ready_n), 32'd1);
        chk("rst_io_r_w", 32'(io_r_w_), 32'd1);
        chk("rst_oe_ff", {30'd0, data_oe_n, ff_oe_n}, 32'd3);
        chk("rst_win", {win_valid, win_index, sel_slot, data_dir}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        cfg_wr(8'h00, 8'h10); cfg_wr(8'h04, 8'hFF); cfg_wr(8'h08, 8'h00); cfg_wr(8'h0C, 8'hFF);
        cfg_wr(8'h01, 8'h20); cfg_wr(8'h05, 8'hF0); cfg_wr(8'h09, 8'h01); cfg_wr(8'h0D, 8'h00);
        cfg_wr(8'h02, 8'h30); cfg_wr(8'h06, 8'hF0); cfg_wr(8'h0A, 8'h01); cfg_wr(8'h0E, 8'h01);
        cfg_wr(8'h03, 8'h00); cfg_wr(8'h07, 8'hFF); cfg_wr(8'h0B, 8'h00); cfg_wr(8'h0F, 8'hFF);
        cfg_wr(8'h10, 8'h77);
        cfg_wr(8'h14, 8'h77);

        // mapped write to window 0
        start_cyc(8'h10, 1'b0);
        chk("w10_hit", {win_valid, win_index, sel_slot}, {24'd0, 1'b1, 4'd0, 3'd0});
        chk("w10_cs_n", 32'(cs_n), 32'h1E);
        chk("w10_data", {data_oe_n, data_dir, ff_oe_n}, 32'b001);
        end_cyc();

        // mapped read to window 2 / slot 1 with busy slot, plus ignored mid-cycle changes
        dev_ready_n = 5'b11101;
        start_cyc(8'h31, 1'b1);
        chk("r31_index", 32'(win_index), 32'd2);
        addr = 8'h77; r_w_ = 1'b0;
        cfg_wr(8'h02, 8'h40);
        for (int k = 0; k < 2; k++) begin
            chk("r31_stretch", {cs_n[1], ready_n, data_dir}, 32'b001);
            @(negedge clk);
        end
        chk("r31_stretch", {cs_n[1], ready_n, data_dir}, 32'b001);
        dev_ready_n = 5'b11111;
        n = 0;
        while (ready_n !== 1'b1 && n < 5) begin @(negedge clk); n++; end
        chk("r31_release", 32'(ready_n), 32'd1);
        iorq_n = 1'b1;
        n = 0;
        while (cs_n[1] !== 1'b1 && n < 4) begin @(negedge clk); n++; end
        chk("r31_cs_release", 32'(cs_n[1]), 32'd1);
        @(negedge clk);
        // the mid-cycle base change now applies: 0x31 no longer hits window 2
        start_cyc(8'h31, 1'b1);
        chk("r31_after_cfg", {win_valid, ff_oe_n}, 32'b00);
        end_cyc();
        cfg_wr(8'h02, 8'h30);

        // unmapped read, busy on slot 0 must not stretch
        dev_ready_n = 5'b11110;
        start_cyc(8'h77, 1'b1);
        chk("r77", {win_valid, data_oe_n, ff_oe_n, ready_n}, 32'b0101);
        end_cyc();
        dev_ready_n = 5'b11111;

        // write to read-only window is unmapped
        start_cyc(8'h31, 1'b0);
        chk("w31", {cs_n, ff_oe_n, win_valid}, {25'd0, 5'h1F, 1'b1, 1'b0});
        end_cyc();

        // mapped write to write-only window 1
        start_cyc(8'h25, 1'b0);
        chk("w25", {win_index, sel_slot, cs_n}, {20'd0, 4'd1, 3'd1, 5'h1D});
        end_cyc();

        // reset aborts an active cycle
        start_cyc(8'h10, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_abort", {cs_n, win_valid, data_oe_n}, {25'd0, 5'h1F, 1'b0, 1'b1});
        iorq_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset config is a catch-all to slot 0
        start_cyc(8'h55, 1'b1);
        chk("r55_reset_cfg", {win_index, cs_n}, {23'd0, 4'd0, 5'h1E});
        end_cyc();

        // a window pointing at a slot past the last one never matches
        cfg_wr(8'h08, 8'h05);
        start_cyc(8'h55, 1'b1);
        chk("r55_bad_slot", {win_index, sel_slot, cs_n}, {20'd0, 4'd1, 3'd0, 5'h1E});
        end_cyc();

`ifdef ADDR_DECODER_READY_TIMEOUT_EN
        dev_ready_n = 5'b11110;
        start_cyc(8'h55, 1'b1);
        n = 0;
        while (ready_n === 1'b0 && n < 400) begin @(negedge clk); n++; end
        chk("timeout_len", n, 32'd256);
        chk("timeout_hold", 32'(ready_n), 32'd1);
        @(negedge clk);
        chk("timeout_hold2", 32'(ready_n), 32'd1);
        end_cyc();
        dev_ready_n = 5'b11111;
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
